// File: rtl/dec4to16_sync.sv
// dec4to16_sync: registered 4-to-16 one-hot decoder with enable.
// Converts a 4-bit select code into a 16-bit one-hot word for chip-select or
// row-select logic. The output is registered by default, so the consumer sees
// no combinational path from the select inputs.
//
// Parameters:
//   OUT_REG    1: one-cycle registered output; 0: combinational output that
//              ignores rst.
//   ACTIVE_LOW 0: the selected bit is 1 and all others are 0.
//              1: the selected bit is 0 and all others are 1.
//
// Optional feature macro: DEC4TO16_VALID_EN
//   When it is defined, the module gains an out_vld output that carries en with
//   the same latency as out. When it is undefined, the port and its logic are
//   absent.
module dec4to16_sync #(
   parameter int OUT_REG    = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  in,
   input  logic        en,
`ifdef DEC4TO16_VALID_EN
   output logic        out_vld,
`endif
   output logic [15:0] out
);

   // Active-high one-hot decode. A disabled decoder selects nothing.
   function automatic logic [15:0] decode(input logic [3:0] code, input logic enable);
      return enable ? (16'h0001 << code) : 16'h0000;
   endfunction

   // Apply the configured output polarity to an active-high word.
   function automatic logic [15:0] polarize(input logic [15:0] d);
      return (ACTIVE_LOW != 0) ? ~d : d;
   endfunction

   // Pattern where no line is selected. It is used for both reset and en=0.
   function automatic logic [15:0] inactive();
      return polarize(16'h0000);
   endfunction

   generate
      if (OUT_REG != 0) begin : g_reg
         logic [15:0] out_p1;

         // ---- stage p0 -> p1: register the decoded word; rst overrides en
         always_ff @(posedge clk) begin
            if (rst) out_p1 <= inactive();
            else     out_p1 <= polarize(decode(in, en));
         end

         assign out = out_p1;

`ifdef DEC4TO16_VALID_EN
         logic vld_p1;

         // Valid travels with the decoded word and is cleared by reset.
         always_ff @(posedge clk) begin
            if (rst) vld_p1 <= 1'b0;
            else     vld_p1 <= en;
         end

         assign out_vld = vld_p1;
`endif
      end else begin : g_comb
         // Combinational build: out follows in/en directly and rst has no effect on it.
         assign out = polarize(decode(in, en));
`ifdef DEC4TO16_VALID_EN
         assign out_vld = en;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_dec4to16_sync.sv
// tb_dec4to16_sync: scoreboard bench for dec4to16_sync in its registered build.
// One instance uses active-high outputs and a second uses active-low outputs.
// Both are driven from the same stimulus.
// The driver pushes each expected response into a queue.
// The monitor compares the DUT outputs one cycle later.
module tb_dec4to16_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [15:0] out_h;
   logic [15:0] out_l;
`ifdef DEC4TO16_VALID_EN
   logic        vld_h;
   logic        vld_l;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        vld;
      int          ones;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   dec4to16_sync #(.OUT_REG(1), .ACTIVE_LOW(0)) dut_h (
      .clk(clk), .rst(rst), .in(sel), .en(en),
`ifdef DEC4TO16_VALID_EN
      .out_vld(vld_h),
`endif
      .out(out_h)
   );

   dec4to16_sync #(.OUT_REG(1), .ACTIVE_LOW(1)) dut_l (
      .clk(clk), .rst(rst), .in(sel), .en(en),
`ifdef DEC4TO16_VALID_EN
      .out_vld(vld_l),
`endif
      .out(out_l)
   );

   // Reference model: builds the response line by line from the selection rule.
   // Line i is active exactly when the module is out of reset, enabled, and i
   // equals the code.
   function automatic exp_t model(input logic r, input logic e, input logic [3:0] c);
      exp_t x;
      x.hi   = '0;
      x.ones = 0;
      for (int i = 0; i < 16; i++) begin
         if (!r && e && (i == int'(c))) begin
            x.hi[i] = 1'b1;
            x.ones++;
         end
      end
      x.lo  = ~x.hi;
      x.vld = !r && e;
      return x;
   endfunction

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic [3:0] c);
      @(negedge clk);
      rst = r;
      en  = e;
      sel = c;
      sb.push_back(model(r, e, c));
   endtask

   // Monitor: one edge after each drive, pop the expected response and compare.
   initial begin
      exp_t x;
      int   ones;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check16("out_active_high", out_h, x.hi);
            check16("out_active_low", out_l, x.lo);
            ones = 0;
            for (int i = 0; i < 16; i++) ones += int'(out_h[i]);
            check16("popcount", 16'(ones), 16'(x.ones));
`ifdef DEC4TO16_VALID_EN
            check16("out_vld_high", {15'h0, vld_h}, {15'h0, x.vld});
            check16("out_vld_low", {15'h0, vld_l}, {15'h0, x.vld});
`endif
         end
      end
   end

   // Driver: directed cases first, then randomized traffic.
   initial begin
      logic [3:0] codes[5];
      codes = '{4'h2, 4'h5, 4'h7, 4'hE, 4'hC};

      // Hold reset for two cycles while the inputs ask to decode code 5.
      drive(1'b1, 1'b1, 4'h5);
      drive(1'b1, 1'b1, 4'h5);
      // When disabled, the code is ignored.
      drive(1'b0, 1'b0, 4'h0);
      drive(1'b0, 1'b0, 4'h8);
      // Send the directed codes back-to-back.
      foreach (codes[k]) drive(1'b0, 1'b1, codes[k]);
      // Sweep every code, including the boundary codes 0 and 15.
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i));
      // Assert reset in the middle of a stream, then release it.
      drive(1'b0, 1'b1, 4'h3);
      drive(1'b1, 1'b1, 4'h3);
      drive(1'b0, 1'b1, 4'h3);
      // Randomized traffic with occasional resets and disables.
      for (int n = 0; n < 300; n++) begin
         drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 15)));
      end
      drive(1'b0, 1'b0, 4'h0);

      // Drain the scoreboard within a fixed cycle budget.
      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
      @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
